// File: rtl/dmem_uart_pkg.sv
// Shared definitions for the data-memory-mapped UART transmitter:
// register offsets, STATUS/CTRL bit positions and serial FSM states.
package dmem_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/dmem_uart_tx_if.sv
// Core data-memory bus as seen by a responder: level-qualified address,
// read/write strobe, write data and registered read data.
interface dmem_uart_tx_if;
  logic [31:0] ADDR;
  logic        DnRW;
  logic [31:0] WDATA;
  logic [31:0] RDATA;

  modport master (output ADDR, output DnRW, output WDATA, input RDATA);
  modport slave  (input ADDR, input DnRW, input WDATA, output RDATA);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; a push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          accept
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop_ok;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign pop_ok = pop && !empty;
  assign accept = push && (!full || pop_ok);
  // Head is read combinationally so the popping edge captures it directly.
  assign dout   = mem[rptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + AW'(1);
      if (pop_ok) rptr <= rptr + AW'(1);
      count <= count + CW'(accept) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus: register decode,
// TX FIFO and bit-serial engine sharing the core clock.
module dmem_uart_tx
  import dmem_uart_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'hFFFF_0000,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_uart_tx_if.slave  bus,
  output logic           TXD,
  output logic           IRQ
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          hit, wr, rd;
  logic [1:0]    sel;
  logic          push, pop, accept, full, empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] count;
  logic [15:0]   baud_div;
  logic          en, irqen, ovf;
  logic [31:0]   status, rd_mux;

  tx_state_e     state, state_nxt;
  logic [15:0]   bit_cnt, bit_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          txd_nxt, bit_end, busy;

  logic unused_bits;
  assign unused_bits = ^{bus.ADDR[1:0], bus.WDATA[31:16]};

  assign hit  = (bus.ADDR[31:4] == BASE[31:4]);
  assign wr   = hit && bus.DnRW;
  assign rd   = hit && !bus.DnRW;
  assign sel  = bus.ADDR[3:2];
  assign push = wr && (sel == REG_TXDATA);
  assign busy = (state != IDLE);

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (CLK),
    .rst_n  (RST),
    .push   (push),
    .din    (bus.WDATA[7:0]),
    .pop    (pop),
    .dout   (fifo_dout),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .accept (accept)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      baud_div <= DEFAULT_DIV;
      en       <= 1'b1;
      irqen    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (wr && sel == REG_BAUDDIV) baud_div <= bus.WDATA[15:0];
      if (wr && sel == REG_CTRL) begin
        en    <= bus.WDATA[CTRL_EN];
        irqen <= bus.WDATA[CTRL_IRQEN];
      end
      if (push && !accept)                                ovf <= 1'b1;
      else if (wr && sel == REG_STATUS && bus.WDATA[ST_OVF]) ovf <= 1'b0;
    end
  end

  always_comb begin
    status                   = '0;
    status[ST_FULL]          = full;
    status[ST_EMPTY]         = empty;
    status[ST_BUSY]          = busy;
    status[ST_OVF]           = ovf;
    status[ST_CNT_LSB +: 8]  = 8'(count);
    rd_mux = '0;
    case (sel)
      REG_STATUS:  rd_mux = status;
      REG_BAUDDIV: rd_mux = {16'd0, baud_div};
      REG_CTRL:    rd_mux = {30'd0, irqen, en};
      default:     rd_mux = '0;
    endcase
  end

  // SRAM-like timing: data appears the cycle after the address; anything else zeroes it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) bus.RDATA <= '0;
    else      bus.RDATA <= rd ? rd_mux : '0;
  end

  assign bit_end = (bit_cnt == 16'd0);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    txd_nxt     = 1'b1;
    // Reloading from the live register lets a new divider apply at the next bit.
    if (state != IDLE) bit_cnt_nxt = bit_end ? baud_div : bit_cnt - 16'd1;
    case (state)
      IDLE: if (en && !empty) begin
        pop         = 1'b1;
        shift_nxt   = fifo_dout;
        bit_cnt_nxt = baud_div;
        state_nxt   = START;
      end
      START: if (bit_end) begin
        bit_idx_nxt = '0;
        state_nxt   = DATA;
      end
      DATA: if (bit_end) begin
        shift_nxt   = {1'b0, shift[7:1]};
        bit_idx_nxt = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (bit_end) begin
        if (en && !empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // TXD follows the next state so the start bit begins on the popping edge.
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TXD     <= 1'b1;
      IRQ     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      TXD     <= txd_nxt;
      IRQ     <= irqen && empty && (state == IDLE);
    end
  end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Directed bench for dmem_uart_tx: register access, framing, back-to-back
// frames, FIFO overflow, interrupt timing and asynchronous reset.
module tb_dmem_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic CLK = 1'b0;
  logic RST;
  logic TXD, IRQ;

  dmem_uart_tx_if bus();

  dmem_uart_tx #(.BASE(BASE), .DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus),
    .TXD (TXD),
    .IRQ (IRQ)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called at a negedge; the access lands on the following posedge.
  task automatic bus_wr(input logic [3:0] off, input logic [31:0] d);
    bus.ADDR = BASE | 32'(off); bus.DnRW = 1'b1; bus.WDATA = d;
    @(negedge CLK);
    bus.ADDR = '0; bus.DnRW = 1'b0; bus.WDATA = '0;
  endtask

  task automatic bus_rd(input logic [3:0] off, output logic [31:0] d);
    bus.ADDR = BASE | 32'(off); bus.DnRW = 1'b0;
    @(negedge CLK);
    d = bus.RDATA;
    bus.ADDR = '0;
  endtask

  // Samples TXD once per cycle starting now; every bit slot must be stable.
  task automatic rx_frames(input string tag, input int d, input logic [7:0] b[$]);
    foreach (b[k]) begin
      logic [9:0] obs;
      logic       unstable;
      obs = '0; unstable = 1'b0;
      for (int s = 0; s < 10; s++) begin
        for (int c = 0; c <= d; c++) begin
          if (c == 0) obs[s] = TXD;
          else if (TXD !== obs[s]) unstable = 1'b1;
          @(negedge CLK);
        end
      end
      chk($sformatf("%s_frame%0d", tag, k), {21'd0, unstable, obs}, {21'd0, 1'b0, 1'b1, b[k], 1'b0});
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  q[$];
    int          lows;

    RST = 1'b0; bus.ADDR = '0; bus.DnRW = 1'b0; bus.WDATA = '0;
    repeat (3) @(negedge CLK);
    chk("rst_txd", 32'(TXD), 32'd1);
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_rdata", bus.RDATA, 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    bus_rd(4'h4, d); chk("rst_status", d, 32'h0000_0002);
    bus_rd(4'h8, d); chk("rst_bauddiv", d, 32'h0000_01B1);
    bus_rd(4'hC, d); chk("rst_ctrl", d, 32'h0000_0001);
    bus_rd(4'h0, d); chk("rd_txdata", d, 32'h0);
    bus_rd(4'h8, d);
    bus_wr(4'h8, 32'd3);
    chk("rdata_on_wr", bus.RDATA, 32'h0);
    bus_rd(4'h8, d); chk("bauddiv_rb", d, 32'd3);
    @(negedge CLK);
    chk("rdata_miss", bus.RDATA, 32'h0);

    // Single 0x55 frame, 4 cycles per bit
    bus_wr(4'h0, 32'h55);
    chk("t2_pre", 32'(TXD), 32'd1);
    @(negedge CLK);
    chk("t2_fall", 32'(TXD), 32'd0);
    q.delete(); q.push_back(8'h55);
    rx_frames("t2", 3, q);
    chk("t2_idle", 32'(TXD), 32'd1);
    repeat (5) @(negedge CLK);
    chk("t2_idle_hold", 32'(TXD), 32'd1);

    // Two back-to-back frames at 1 cycle per bit
    bus_wr(4'h8, 32'd0);
    bus_wr(4'h0, 32'hA5);
    bus_wr(4'h0, 32'h3C);
    q.delete(); q.push_back(8'hA5); q.push_back(8'h3C);
    rx_frames("t3", 0, q);
    chk("t3_idle", 32'(TXD), 32'd1);
    bus_rd(4'h4, d); chk("t3_status", d, 32'h0000_0002);

    // Overflow with transmitter disabled, then drain in order
    bus_wr(4'hC, 32'd0);
    for (int i = 0; i < 9; i++) bus_wr(4'h0, 32'h10 + 32'(i));
    bus_rd(4'h4, d); chk("t4_full_ovf", d, 32'h0000_0809);
    bus_wr(4'h4, 32'h8);
    bus_rd(4'h4, d); chk("t4_ovf_clr", d, 32'h0000_0801);
    bus_wr(4'hC, 32'd1);
    chk("t4_pre", 32'(TXD), 32'd1);
    @(negedge CLK);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'h10 + 8'(i));
    rx_frames("t4", 0, q);
    bus_rd(4'h4, d); chk("t4_drained", d, 32'h0000_0002);

    // Interrupt on drain
    bus_wr(4'h8, 32'd1);
    bus_wr(4'hC, 32'd3);
    @(negedge CLK);
    chk("t5_irq_idle", 32'(IRQ), 32'd1);
    bus_wr(4'h0, 32'h96);
    chk("t5_irq_pre", 32'(IRQ), 32'd1);
    @(negedge CLK);
    chk("t5_irq_busy", 32'(IRQ), 32'd0);
    q.delete(); q.push_back(8'h96);
    rx_frames("t5", 1, q);
    chk("t5_irq_lag", 32'(IRQ), 32'd0);
    @(negedge CLK);
    chk("t5_irq_rise", 32'(IRQ), 32'd1);
    bus_wr(4'hC, 32'd1);

    // Reset in the middle of a data bit
    bus_wr(4'h8, 32'd3);
    bus_wr(4'h0, 32'h00);
    bus_wr(4'h0, 32'h00);
    repeat (10) @(negedge CLK);
    chk("t6_data_low", 32'(TXD), 32'd0);
    #2 RST = 1'b0;
    #1 chk("t6_async_txd", 32'(TXD), 32'd1);
    chk("t6_async_rdata", bus.RDATA, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    bus_rd(4'h4, d); chk("t6_status", d, 32'h0000_0002);
    bus_rd(4'h8, d); chk("t6_bauddiv", d, 32'h0000_01B1);
    lows = 0;
    repeat (60) begin
      @(negedge CLK);
      if (TXD !== 1'b1) lows++;
    end
    chk("t6_no_frame", 32'(lows), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_uart_tx.md
Name: dmem_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the core's data-memory bus (address, read/write strobe, write data, read data).
- Sits beside data SRAM; top-level address decode is done inside via BASE.
- Core writes bytes into a TX FIFO; a bit-serial engine shifts frames out on TXD (8N1, LSB first).
- Exposes status, baud divider and control registers; raises a level interrupt when the transmitter drains.

Parameters:
- BASE, 32'hFFFF_0000, byte base address; block occupies BASE..BASE+0xF.
- DEPTH, 8, FIFO depth in bytes; power of 2, 2..64.
- DEFAULT_DIV, 16'd433, reset value of BAUDDIV.

Ports:
- CLK  input  1  core clock; bus and serial engine share it.
- RST  input  1  asynchronous, active-low reset.
- ADDR  input  32  bus byte address; ADDR[3:2] selects register.
- DnRW  input  1  0 = read, 1 = write; level-qualified every cycle.
- WDATA  input  32  bus write data.
- RDATA  output  32  bus read data, registered.
- TXD  output  1  serial line, idle high, registered.
- IRQ  output  1  level interrupt, registered.

Behaviour:
- Hit: ADDR[31:4] == BASE[31:4]. A write takes effect on every rising edge with hit && DnRW=1. No wait states.
- Reads:
  - RDATA is updated at the edge when hit && DnRW=0, giving 1-cycle latency (same timing as SRAM).
  - On a miss, or on a write, RDATA is loaded with 0.
  - Reads have no side effects.
- Register map:
  - 0x0 TXDATA: a write pushes WDATA[7:0]; a read returns 0.
  - 0x4 STATUS (read):
    - bit0 full, bit1 empty, bit2 busy (state != IDLE), bit3 ovf (sticky).
    - [15:8] FIFO count.
    - A write with WDATA[3]=1 clears ovf; other bits are ignored.
  - 0x8 BAUDDIV: R/W, [15:0]; bit period = BAUDDIV+1 cycles. BAUDDIV=0 is legal (1 cycle per bit).
  - 0xC CTRL: R/W.
    - bit0 EN, reset 1.
    - bit1 IRQEN, reset 0.
- FIFO:
  - Push is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and ovf is set.
  - Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TXD=1. If EN and the FIFO is not empty: pop into an 8-bit shift register, load the bit counter from BAUDDIV, go to START.
  - START: TXD=0 for BAUDDIV+1 cycles, then DATA.
  - DATA: TXD = shift[0]. At the end of each bit, shift right. After 8 bits, go to STOP.
  - STOP: TXD=1 for one bit.
    - At the end of the bit, if EN and the FIFO is not empty: pop and go directly to START (no gap).
    - Otherwise go to IDLE.
- Timing:
  - Frame = 10*(BAUDDIV+1) cycles.
  - A push at edge E into an empty, idle block pops at edge E+1; TXD falls after E+1.
- BAUDDIV written mid-frame: takes effect at the next bit boundary (the bit counter reloads from the register).
- EN cleared mid-frame: the current frame completes, then the FSM goes to IDLE. The FIFO contents are retained.
- IRQ = IRQEN && empty && state==IDLE, registered.
- Reset:
  - TXD=1, RDATA=0, IRQ=0, state IDLE.
  - FIFO empty, ovf=0, BAUDDIV=DEFAULT_DIV, CTRL=2'b01.
  - An assertion mid-frame forces TXD high immediately (asynchronous).

Decomposition:
- Package dmem_uart_pkg:
  - Register offsets (TXDATA, STATUS, BAUDDIV, CTRL).
  - STATUS bit positions.
  - CTRL bit positions.
  - FSM state encoding.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop, count/full/empty, and an accept output that implements the push-with-pop rule.
- The serial FSM and bus decode stay in the top module.

Test Plan:
- Reset, then read BASE+0x4 and BASE+0x8:
  - RDATA = 0x0000_0002 (empty) one cycle later, then 0x0000_01B1.
  - TXD=1, IRQ=0.
- BAUDDIV=3, then write 0x55 to TXDATA:
  - TXD falls 1 cycle after the push.
  - The line reads, each bit held 4 cycles: 0,1,0,1,0,1,0,1,0,1.
  - The frame lasts 40 cycles, then TXD stays 1.
- BAUDDIV=0, then push 0xA5 and 0x3C back-to-back:
  - Frames are contiguous with no idle cycle: 20 cycles total.
  - STATUS then reads empty, busy=0.
- DEPTH=8 with EN=0: push 9 bytes:
  - STATUS count=8, full=1, ovf=1.
  - Write 0x8 to STATUS: ovf=0.
  - Set EN=1: 8 frames are sent in push order.
- IRQEN=1, push one byte at BAUDDIV=1:
  - IRQ drops while busy.
  - IRQ rises 1 cycle after the FSM returns to IDLE.
- Assert RST during the DATA state of a frame:
  - TXD=1 immediately, FIFO empty.
  - No further frame after release.
